// File: rtl/fb_scanout.sv
// Framebuffer reader: snapshots the renderer's pixel vector once per frame
// and scans it out as upscaled VGA with 3-3-2 colour.
module fb_scanout #(
  parameter int PX_WIDTH  = 80,
  parameter int PX_HEIGHT = 60,
  parameter int SCALE     = 8,
  parameter int CLK_DIV   = 4,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PX_WIDTH*PX_HEIGHT*3:0]   pixel,
  output logic                            hsync,
  output logic                            vsync,
  output logic [2:0]                      vga_r,
  output logic [2:0]                      vga_g,
  output logic [1:0]                      vga_b,
  output logic                            frame_start,
  output logic [9:0]                      hcount,
  output logic [9:0]                      vcount
);

  localparam int NBITS = PX_WIDTH * PX_HEIGHT * 3;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW    = (NBITS > 2) ? $clog2(NBITS) : 1;
  localparam int SH    = $clog2(SCALE);

  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST =
    10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST =
    10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] IMG_W  = 10'(PX_WIDTH * SCALE);
  localparam logic [9:0] IMG_H  = 10'(PX_HEIGHT * SCALE);
  localparam logic [9:0] SNAP_V = 10'(V_ACTIVE - 1);

  logic [DW-1:0]    r_div;
  logic [9:0]       r_hc;
  logic [9:0]       r_vc;
  logic [NBITS-1:0] r_shadow;
  logic             r_seen;

  logic             w_tick;
  logic             w_hwrap;
  logic             w_snap;
  logic             w_in;
  logic [9:0]       w_fx;
  logic [9:0]       w_fy;
  logic [IW-1:0]    w_idx;
  logic [2:0]       w_code;
  logic             w_unused;

  assign w_unused = pixel[NBITS];

  assign w_tick  = (r_div == DIV_MAX);
  assign w_hwrap = (r_hc == H_LAST);
  assign w_snap  = w_tick && w_hwrap && (r_vc == SNAP_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_tick) begin
      if (w_hwrap) begin
        r_hc <= '0;
        r_vc <= (r_vc == V_LAST) ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Only this one tick may change the shadow, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (w_snap) begin
      r_shadow <= pixel[NBITS-1:0];
    end
  end

  assign w_in  = (r_hc < IMG_W) && (r_vc < IMG_H);
  assign w_fx  = r_hc >> SH;
  assign w_fy  = r_vc >> SH;
  assign w_idx = IW'((32'(w_fy) * 32'(PX_WIDTH) + 32'(w_fx)) * 32'd3);

  always_comb begin
    w_code = 3'b000;
    if (w_in) begin
      w_code = r_shadow[w_idx +: 3];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (w_tick) begin
      hsync <= !((r_hc >= HS_BEG) && (r_hc < HS_END));
      vsync <= !((r_vc >= VS_BEG) && (r_vc < VS_END));
      vga_r <= {3{w_code[2]}};
      vga_g <= {3{w_code[1]}};
      vga_b <= {2{w_code[0]}};
    end
  end

  // The first tick after reset sits at (0,0) but is not a new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen      <= 1'b0;
      frame_start <= 1'b0;
    end else if (w_tick) begin
      r_seen      <= 1'b1;
      frame_start <= r_seen && (r_hc == 10'd0) && (r_vc == 10'd0);
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign hcount = r_hc;
  assign vcount = r_vc;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: reduced timing, random framebuffer updates,
// per-cycle comparison against a frame-position model.
module tb_fb_scanout;

  localparam int PW  = 8;
  localparam int PH  = 6;
  localparam int SC  = 4;
  localparam int CD  = 2;
  localparam int HA  = 40;
  localparam int HFP = 2;
  localparam int HS  = 4;
  localparam int HBP = 2;
  localparam int VA  = 28;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 2;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;
  localparam int SNAP = (VA - 1) * HT + HT - 1;
  localparam int NB  = PW * PH * 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB:0]   pixel = '0;
  logic          hsync;
  logic          vsync;
  logic [2:0]    vga_r;
  logic [2:0]    vga_g;
  logic [1:0]    vga_b;
  logic          frame_start;
  logic [9:0]    hcount;
  logic [9:0]    vcount;

  fb_scanout #(
    .PX_WIDTH(PW), .PX_HEIGHT(PH), .SCALE(SC), .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel(pixel),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start),
    .hcount(hcount), .vcount(vcount)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int n = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n <= 0;
    else n <= n + 1;
  end

  int         sh [PH][PW];
  logic       e_hs = 1'b1;
  logic       e_vs = 1'b1;
  logic       e_fs = 1'b0;
  logic [2:0] e_code = 3'b000;

  always @(negedge clk) begin : cmp
    int t, p, hc, vc, pos;
    logic [30:0] got, want;
    if (!rst_n) begin
      foreach (sh[y, x]) sh[y][x] = 0;
      e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_code = 3'b000;
    end else if (n > 0 && n % CD == 0) begin
      t  = n / CD;
      p  = (t - 1) % FT;
      hc = p % HT;
      vc = p / HT;
      e_hs = !(hc >= HA + HFP && hc < HA + HFP + HS);
      e_vs = !(vc >= VA + VFP && vc < VA + VFP + VS);
      e_code = (hc < PW * SC && vc < PH * SC) ? 3'(sh[vc / SC][hc / SC]) : 3'b000;
      e_fs = (p == 0) && (t > 1);
      if (p == SNAP)
        foreach (sh[y, x]) sh[y][x] = int'(pixel[(y * PW + x) * 3 +: 3]);
    end else begin
      e_fs = 1'b0;
    end
    pos = (n / CD) % FT;
    want = {e_hs, e_vs, {3{e_code[2]}}, {3{e_code[1]}}, {2{e_code[0]}},
            e_fs, 10'(pos % HT), 10'(pos / HT)};
    got  = {hsync, vsync, vga_r, vga_g, vga_b, frame_start, hcount, vcount};
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL scan n=%0d got %h want %h", n, got, want);
    end
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    vectors++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp_v);
    end
  endtask

  function automatic int rgb();
    return int'({vga_r, vga_g, vga_b});
  endfunction

  task automatic wait_pos(input int hc, input int vc);
    for (int k = 0; k < FT * CD + 8; k++) begin
      @(negedge clk);
      if (hcount == 10'(hc + 1) && vcount == 10'(vc)) return;
    end
    chk("wait_pos_timeout", hc, -1);
  endtask

  task automatic wait_fs();
    for (int k = 0; k < FT * CD + 8; k++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    chk("wait_fs_timeout", 0, 1);
  endtask

  task automatic wait_low(input bit vs_sel, output int len);
    len = 0;
    for (int k = 0; k < FT * CD + 8; k++) begin
      @(negedge clk);
      if ((vs_sel ? vsync : hsync) == 1'b0) break;
    end
    chk(vs_sel ? "vs_start_line" : "hs_start_col",
        vs_sel ? int'(vcount) : int'(hcount),
        vs_sel ? VA + VFP : HA + HFP + 1);
    for (int k = 0; k < FT * CD + 8; k++) begin
      if ((vs_sel ? vsync : hsync) == 1'b1) break;
      len++;
      @(negedge clk);
    end
  endtask

  time t1, t2;
  int  len;

  initial begin
    repeat (10) @(negedge clk);
    chk("rst_hcount", int'(hcount), 0);
    chk("rst_vcount", int'(vcount), 0);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rgb", rgb(), 0);
    #1 rst_n = 1'b1;
    repeat (CD - 1) @(negedge clk);
    chk("hc_before_tick", int'(hcount), 0);
    @(negedge clk);
    chk("hc_first_tick", int'(hcount), 1);
    #1;
    pixel[2:0] = 3'b100;
    pixel[(5 * PW + 7) * 3 +: 3] = 3'b111;

    wait_low(1'b0, len);
    chk("hs_len", len, HS * CD);
    wait_low(1'b1, len);
    chk("vs_len", len, VS * HT * CD);

    wait_fs();
    t1 = $time;
    chk("f1_00_red", rgb(), 224);
    wait_pos(4, 0);
    chk("f1_40_black", rgb(), 0);
    wait_pos(3, 3);
    chk("f1_33_red", rgb(), 224);
    wait_pos(0, 10);
    #1;
    pixel[2:0] = 3'b010;
    pixel[(5 * PW + 7) * 3 +: 3] = 3'b000;
    wait_pos(31, 23);
    chk("f1_corner_white", rgb(), 255);
    wait_pos(32, 23);
    chk("f1_margin_black", rgb(), 0);

    wait_fs();
    t2 = $time;
    chk("fs_period_clk", int'((t2 - t1) / 10), FT * CD);
    chk("f2_00_green", rgb(), 28);
    wait_pos(31, 23);
    chk("f2_corner_black", rgb(), 0);

    for (int r = 0; r < 40; r++) begin
      repeat ($urandom_range(20, 600)) @(negedge clk);
      #1;
      for (int i = 0; i <= NB; i++) pixel[i] = 1'($urandom);
    end

    @(negedge clk);
    #1;
    for (int i = 0; i < PW * PH; i++) pixel[i * 3 +: 3] = 3'b111;
    wait_fs();
    wait_fs();
    wait_pos(0, 15);
    chk("pre_rst_white", rgb(), 255);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_hcount", int'(hcount), 0);
    chk("arst_vcount", int'(vcount), 0);
    chk("arst_rgb", rgb(), 0);
    chk("arst_hsync", int'(hsync), 1);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    wait_pos(0, 0);
    chk("post_rst_00_black", rgb(), 0);
    wait_pos(20, 12);
    chk("post_rst_mid_black", rgb(), 0);
    wait_fs();
    chk("post_snap_white", rgb(), 255);
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
